// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_pkg
//  Description : Shared definitions for the multi-key debouncer.
//                - 2-bit per-key state encoding
//                - default tick divider (1 ms at 100 MHz)
//                - counter width helper that never returns a zero width
//  Revision    : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } key_state_e;

    // clk cycles per millisecond tick at 100 MHz
    localparam int unsigned c_DEF_TICK_DIV = 100_000;

    // Width needed to hold values 0..n-1. A one-value range still gets
    // one bit, so degenerate parameters never produce [-1:0] vectors.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : key_debounce_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One key channel: 2-FF synchroniser, polarity normalise and
//                the debounce / hold / repeat state machine. All timing is
//                counted in shared ticks supplied by the parent.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                key_raw         raw asynchronous key pin
//                tick            one-clk strobe from the shared tick divider
//                key_level       debounced level, 1 = pressed
//                key_press       1-clk pulse on accepted press
//                key_release     1-clk pulse on accepted release
//                key_long        1-clk pulse once per hold at LONG_TICKS
//                key_rpt         1-clk pulse every REPEAT_TICKS after key_long
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DB_TICKS     = 20,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200,
    parameter bit          REPEAT_EN    = 1'b1,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic tick,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_rpt
);

    localparam int unsigned c_DCNT_W = cnt_width(DB_TICKS + 1);
    localparam int unsigned c_HCNT_W = cnt_width(LONG_TICKS + 1);
    localparam int unsigned c_RCNT_W = cnt_width(REPEAT_TICKS + 1);

    localparam logic [c_DCNT_W-1:0] c_DB_LAST   = c_DCNT_W'(DB_TICKS - 1);
    localparam logic [c_HCNT_W-1:0] c_LONG      = c_HCNT_W'(LONG_TICKS);
    localparam logic [c_HCNT_W-1:0] c_LONG_LAST = c_HCNT_W'(LONG_TICKS - 1);
    localparam logic [c_RCNT_W-1:0] c_RPT_LAST  = c_RCNT_W'(REPEAT_TICKS - 1);

    // Pin level that means "not pressed"; the synchroniser starts there so
    // reset release never looks like a press edge.
    localparam logic c_RELEASED = ACTIVE_LOW;

    logic [1:0]          r_sync;
    logic                w_p;
    key_state_e          r_state;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic [c_HCNT_W-1:0] r_hcnt;
    logic                w_hold_tick;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchroniser, then p = 1 means pressed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{c_RELEASED}};
        end else begin
            r_sync <= {r_sync[0], key_raw};
        end
    end

    assign w_p = r_sync[1] ^ ACTIVE_LOW;

    // A tick that advances the hold timer: key held and still pressed.
    assign w_hold_tick = (r_state == ST_HELD) && w_p && tick;

    // ------------------------------------------------------------------
    // Debounce / hold state machine. hcnt saturates at LONG_TICKS, which
    // both marks "long already fired" and gates the repeat counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_p) begin
                        r_state <= ST_PRESS_DB;
                        r_dcnt  <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_p) begin
                        r_state <= ST_IDLE;
                    end else if (tick) begin
                        if (r_dcnt == c_DB_LAST) begin
                            r_state   <= ST_HELD;
                            key_press <= 1'b1;
                            key_level <= 1'b1;
                            r_hcnt    <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (!w_p) begin
                        r_state <= ST_RELEASE_DB;
                        r_dcnt  <= '0;
                    end else if (tick && (r_hcnt != c_LONG)) begin
                        r_hcnt <= r_hcnt + 1'b1;
                        if (r_hcnt == c_LONG_LAST) begin
                            key_long <= 1'b1;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    // Bounce back to pressed: hold timing resumes where it
                    // stopped, and no second press is reported.
                    if (w_p) begin
                        r_state <= ST_HELD;
                    end else if (tick) begin
                        if (r_dcnt == c_DB_LAST) begin
                            r_state     <= ST_IDLE;
                            key_release <= 1'b1;
                            key_level   <= 1'b0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat. Counting starts on the tick after key_long, so the
    // first repeat can never coincide with the long pulse.
    // ------------------------------------------------------------------
    generate
        if (REPEAT_EN) begin : g_rpt_on
            logic [c_RCNT_W-1:0] r_rcnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rcnt  <= '0;
                    key_rpt <= 1'b0;
                end else begin
                    key_rpt <= 1'b0;
                    if (w_hold_tick) begin
                        if (r_hcnt == c_LONG_LAST) begin
                            r_rcnt <= '0;
                        end else if (r_hcnt == c_LONG) begin
                            if (r_rcnt == c_RPT_LAST) begin
                                r_rcnt  <= '0;
                                key_rpt <= 1'b1;
                            end else begin
                                r_rcnt <= r_rcnt + 1'b1;
                            end
                        end
                    end
                end
            end
        end else begin : g_rpt_off
            assign key_rpt = 1'b0;
        end
    endgenerate

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_multi
//  Description : N-key debouncer / key-event generator. One free-running
//                tick divider is shared by NUM_KEYS independent channels.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                key_in          raw asynchronous key pins
//                key_level       debounced state per key, 1 = pressed
//                key_press       1-clk pulse per key on accepted press
//                key_release     1-clk pulse per key on accepted release
//                key_long        1-clk pulse per key at LONG_TICKS of hold
//                key_rpt         1-clk pulse per key every REPEAT_TICKS
//                                after key_long (0 when REPEAT_EN = 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_multi
    import key_debounce_pkg::*;
#(
    parameter int          NUM_KEYS     = 4,
    parameter int unsigned TICK_DIV     = c_DEF_TICK_DIV,
    parameter int unsigned DB_TICKS     = 20,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200,
    parameter bit          REPEAT_EN    = 1'b1,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_rpt
);

    localparam int unsigned          c_TICK_W    = cnt_width(TICK_DIV);
    localparam logic [c_TICK_W-1:0]  c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    // Free-running 0..TICK_DIV-1; the tick is the cycle in which it wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_debounce_ch #(
                .DB_TICKS     (DB_TICKS),
                .LONG_TICKS   (LONG_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS),
                .REPEAT_EN    (REPEAT_EN),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .key_raw     (key_in[i]),
                .tick        (w_tick),
                .key_level   (key_level[i]),
                .key_press   (key_press[i]),
                .key_release (key_release[i]),
                .key_long    (key_long[i]),
                .key_rpt     (key_rpt[i])
            );
        end
    endgenerate

endmodule : key_debounce_multi
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce_multi
//  Description : Self-checking bench for key_debounce_multi. Two DUTs share
//                the key pins: one with auto-repeat, one without. A
//                behavioural model tracks each key by tick counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

    localparam int TD   = 4;
    localparam int DB   = 3;
    localparam int LONG = 10;
    localparam int RPT  = 4;
    localparam int NK   = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;

    logic [NK-1:0] key_level, key_press, key_release, key_long, key_rpt;
    logic [NK-1:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;

    int errors = 0;
    int checks = 0;
    int cycn   = 0;

    // ---------------- model state ----------------
    logic [NK-1:0] m_lvl, m_prs, m_rel, m_lng, m_rpt;
    logic [NK-1:0] m_pp;          // pressed flag seen at the previous edge
    logic [NK-1:0] h0, h1;        // pin samples one and two edges ago
    int            m_run[NK];     // ticks the new level has been stable
    int            m_held[NK];    // ticks pressed since press accepted
    int            n_edges;

    logic [10*NK-1:0] act_all, exp_all;
    assign act_all = {key_level, key_press, key_release, key_long, key_rpt,
                      lvl_b, prs_b, rel_b, lng_b, rpt_b};
    assign exp_all = {m_lvl, m_prs, m_rel, m_lng, m_rpt,
                      m_lvl, m_prs, m_rel, m_lng, {NK{1'b0}}};

    key_debounce_multi #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LONG),
        .REPEAT_TICKS(RPT), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_rpt(key_rpt)
    );

    key_debounce_multi #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LONG),
        .REPEAT_TICKS(RPT), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
    ) u_dut_norpt (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
        .key_long(lng_b), .key_rpt(rpt_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_rpt = '0;
        m_pp = '0; h0 = '1; h1 = '1; n_edges = 0;
        for (int k = 0; k < NK; k++) begin
            m_run[k] = 0;
            m_held[k] = 0;
        end
    endtask

    // Advance the model by one clock edge. The pressed flag at this edge is
    // the pin value from two edges ago; a tick is the last cycle of every
    // TD-cycle period counted from reset release. A tick only counts toward
    // a level if the key showed that level on this edge and the previous one.
    task automatic model_edge();
        logic [NK-1:0] p;
        bit            tick;
        if (rst_n !== 1'b1) return;
        tick = ((n_edges % TD) == TD - 1);
        p = ~h1;
        m_prs = '0; m_rel = '0; m_lng = '0; m_rpt = '0;
        for (int k = 0; k < NK; k++) begin
            if (p[k] != m_lvl[k]) begin
                if (m_pp[k] != m_lvl[k]) begin
                    if (tick) begin
                        m_run[k]++;
                        if (m_run[k] == DB) begin
                            m_lvl[k] = p[k];
                            if (p[k]) begin
                                m_prs[k] = 1'b1;
                                m_held[k] = 0;
                            end else begin
                                m_rel[k] = 1'b1;
                            end
                            m_run[k] = 0;
                        end
                    end
                end else begin
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
                if (m_lvl[k] && m_pp[k] && tick) begin
                    m_held[k]++;
                    if (m_held[k] == LONG)
                        m_lng[k] = 1'b1;
                    else if (m_held[k] > LONG && ((m_held[k] - LONG) % RPT) == 0)
                        m_rpt[k] = 1'b1;
                end
            end
        end
        m_pp = p;
        h1 = h0;
        h0 = key_in;
        n_edges++;
    endtask

    // One clock: model follows the edge, sampling happens 1 ns later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cycn++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        key_in = '1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 3) key_in = '0;   // pins pressed during reset do nothing
            cyc();
            checks++;
            if (act_all !== '0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%h exp=0", cycn, act_all);
            end
        end
        key_in = '1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bounce();
        int npress = 0, nrel = 0, t_last = 0, t_press = -100;
        int blen = 40 + int'($urandom_range(0, 2));
        logic nv;
        for (int c = 0; c < 170; c++) begin
            nv = key_in[0];
            if (c < blen) begin
                if (c % 3 == 0) nv = ~key_in[0];
            end else if (c < 110) begin
                nv = 1'b0;
            end else begin
                nv = 1'b1;
            end
            if (c < 110 && nv !== key_in[0]) t_last = c;
            key_in[0] = nv;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL bounce cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
            if (c < 110 && key_press[0]) begin npress++; t_press = c; end
            if (c < 110 && key_release[0]) nrel++;
        end
        checks++;
        if (npress != 1) begin
            errors++;
            $display("FAIL bounce_press_count got=%0d exp=1", npress);
        end
        checks++;
        if (nrel != 0) begin
            errors++;
            $display("FAIL bounce_stray_release got=%0d exp=0", nrel);
        end
        checks++;
        if (t_press - t_last < 10 || t_press - t_last > 15) begin
            errors++;
            $display("FAIL bounce_latency got=%0d exp=10..15", t_press - t_last);
        end
    endtask

    // ------------------------------------------------------------------
    // Hold kept below the long-press threshold.
    task automatic test_short_press();
        int hold = int'($urandom_range(24, 40));
        int np = 0, nr = 0, nl = 0, t_rel = -100;
        for (int c = 0; c < hold + 60; c++) begin
            key_in[1] = (c < hold) ? 1'b0 : 1'b1;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL short_press cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
            if (key_press[1]) np++;
            if (key_release[1]) begin nr++; t_rel = c; end
            if (key_long[1]) nl++;
        end
        checks++;
        if (np != 1 || nr != 1) begin
            errors++;
            $display("FAIL short_press_counts got=%0d/%0d exp=1/1", np, nr);
        end
        checks++;
        if (nl != 0) begin
            errors++;
            $display("FAIL short_press_long got=%0d exp=0", nl);
        end
        checks++;
        if (t_rel - hold < 10 || t_rel - hold > 15) begin
            errors++;
            $display("FAIL short_release_latency got=%0d exp=10..15", t_rel - hold);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_long_hold();
        int hold = int'($urandom_range(116, 124));
        int np = 0, nl = 0, nr = 0, nr_b = 0;
        int t_p = -1000, t_l = -1000, t_r1 = -1000, t_r2 = -1000;
        for (int c = 0; c < hold + 60; c++) begin
            key_in[2] = (c < hold) ? 1'b0 : 1'b1;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL long_hold cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
            if (key_press[2]) begin np++; t_p = c; end
            if (key_long[2]) begin nl++; t_l = c; end
            if (key_rpt[2]) begin
                nr++;
                if (nr == 1) t_r1 = c;
                if (nr == 2) t_r2 = c;
            end
            if (rpt_b != 0) nr_b++;
        end
        checks++;
        if (np != 1 || nl != 1) begin
            errors++;
            $display("FAIL long_counts press/long got=%0d/%0d exp=1/1", np, nl);
        end
        checks++;
        if (t_l - t_p != LONG * TD) begin
            errors++;
            $display("FAIL long_delay got=%0d exp=%0d", t_l - t_p, LONG * TD);
        end
        checks++;
        if (nr < 3 || t_r1 - t_l != RPT * TD || t_r2 - t_r1 != RPT * TD) begin
            errors++;
            $display("FAIL repeat_timing got=n%0d d1=%0d d2=%0d exp=n>=3 d=%0d",
                     nr, t_r1 - t_l, t_r2 - t_r1, RPT * TD);
        end
        checks++;
        if (nr_b != 0) begin
            errors++;
            $display("FAIL repeat_disabled got=%0d exp=0", nr_b);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_release_glitch();
        int g = int'($urandom_range(24, 30));
        int np = 0, nr = 0, t_p = -1000, t_l = -1000;
        for (int c = 0; c < 220; c++) begin
            key_in[3] = ((c >= g && c < g + TD) || c >= 150) ? 1'b1 : 1'b0;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL release_glitch cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
            if (c < 150) begin
                if (key_press[3]) begin np++; t_p = c; end
                if (key_release[3]) nr++;
                if (key_long[3]) t_l = c;
            end
        end
        checks++;
        if (np != 1 || nr != 0) begin
            errors++;
            $display("FAIL glitch_counts press/release got=%0d/%0d exp=1/0", np, nr);
        end
        checks++;
        if (t_l - t_p < LONG * TD + TD || t_l - t_p > LONG * TD + 2 * TD) begin
            errors++;
            $display("FAIL glitch_long_delay got=%0d exp=%0d..%0d",
                     t_l - t_p, LONG * TD + TD, LONG * TD + 2 * TD);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_simultaneous();
        logic [NK-1:0] first_p = '0, first_r = '0, first_pb = '0;
        for (int c = 0; c < 90; c++) begin
            key_in = (c < 40) ? '0 : '1;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
            if (first_p == 0) first_p = key_press;
            if (first_pb == 0) first_pb = prs_b;
            if (first_r == 0) first_r = key_release;
        end
        checks++;
        if (first_p !== 4'hF || first_pb !== 4'hF) begin
            errors++;
            $display("FAIL all_press got=%h/%h exp=f", first_p, first_pb);
        end
        checks++;
        if (first_r !== 4'hF) begin
            errors++;
            $display("FAIL all_release got=%h exp=f", first_r);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_hold();
        int np = 0, nr = 0;
        for (int c = 0; c < 30; c++) begin
            key_in[2] = 1'b0;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
        end
        checks++;
        if (key_level[2] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_level got=%b exp=1", key_level[2]);
        end
        #2;
        rst_n = 1'b0;     // between clock edges
        #1;
        checks++;
        if (act_all !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", act_all);
        end
        model_reset();
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++;
            if (act_all !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", cycn, act_all);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            key_in[2] = (c < 40) ? 1'b0 : 1'b1;
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
            if (c < 40 && key_press[2]) np++;
            if (c < 40 && key_release[2]) nr++;
        end
        checks++;
        if (np != 1 || nr != 0) begin
            errors++;
            $display("FAIL fresh_press press/release got=%0d/%0d exp=1/0", np, nr);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int rem[NK];
        for (int k = 0; k < NK; k++) rem[k] = 1;
        for (int c = 0; c < 1600; c++) begin
            for (int k = 0; k < NK; k++) begin
                rem[k]--;
                if (rem[k] <= 0) begin
                    key_in[k] = ~key_in[k];
                    rem[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                         : int'($urandom_range(16, 140));
                end
            end
            cyc();
            checks++;
            if (act_all !== exp_all) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cycn, act_all, exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_press();
        test_long_hold();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_debounce_multi
`default_nettype wire
